// File: rtl/pwm32_pkg.sv
// Shared constants and types for the PWM32 timer engine.
package pwm32_pkg;

  localparam int   TMR_W_DEF      = 32;
  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // Period-boundary copies of the programming registers; sized for the widest timer.
  typedef struct packed {
    logic [TMR_W_DEF-1:0] pre;
    logic [TMR_W_DEF-1:0] cmp1;
    logic [TMR_W_DEF-1:0] cmp2;
  } shadow_t;

endpackage

// File: rtl/pwm32_prescaler.sv
// PCLK divider: emits a tick every pre_sh+1 enabled cycles, held cleared while disabled.
module pwm32_prescaler
  import pwm32_pkg::*;
#(
  parameter int TMR_W = TMR_W_DEF
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             en,
  input  logic [TMR_W-1:0] pre_sh,
  output logic             tick
);

  logic [TMR_W-1:0] pre_cnt_q, pre_cnt_d;

  // The first enabled cycle already counts, so the first tick lands in cycle pre_sh+1.
  always_comb begin
    tick      = en && (pre_cnt_q == pre_sh);
    pre_cnt_d = pre_cnt_q + TMR_W'(1);
    if (!en || tick) pre_cnt_d = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) pre_cnt_q <= '0;
    else          pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/pwm32_core.sv
// PWM timer engine: prescaled period counter with double-buffered period/duty compares.
module pwm32_core
  import pwm32_pkg::*;
#(
  parameter int   TMR_W      = TMR_W_DEF,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [TMR_W-1:0] PRE,
  input  logic [TMR_W-1:0] TMRCMP1,
  input  logic [TMR_W-1:0] TMRCMP2,
  input  logic             TMREN,
  output logic             pwm_out,
  output logic             period_end,
  output logic [TMR_W-1:0] tmr_value
);

  shadow_t          sh_q, sh_d, sh_load;
  logic [TMR_W-1:0] tmr_cnt_q, tmr_cnt_d;
  logic [TMR_W-1:0] tmr_value_q;
  logic [TMR_W-1:0] pre_sh, cmp1_sh, cmp2_sh;
  logic             pwm_out_q, pwm_out_d;
  logic             period_end_q, period_end_d;
  logic             tick;

  assign pre_sh  = sh_q.pre[TMR_W-1:0];
  assign cmp1_sh = sh_q.cmp1[TMR_W-1:0];
  assign cmp2_sh = sh_q.cmp2[TMR_W-1:0];

  assign sh_load = '{pre:  TMR_W_DEF'(PRE),
                     cmp1: TMR_W_DEF'(TMRCMP1),
                     cmp2: TMR_W_DEF'(TMRCMP2)};

  pwm32_prescaler #(.TMR_W(TMR_W)) u_pre (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .en      (TMREN),
    .pre_sh  (pre_sh),
    .tick    (tick)
  );

  // Disable takes priority over a coinciding wrap: no pulse, only the disabled-mode load.
  always_comb begin
    sh_d         = sh_q;
    tmr_cnt_d    = tmr_cnt_q;
    period_end_d = 1'b0;
    pwm_out_d    = IDLE_LEVEL;
    if (!TMREN) begin
      sh_d      = sh_load;
      tmr_cnt_d = '0;
    end else begin
      pwm_out_d = (tmr_cnt_q < cmp2_sh);
      if (tick) begin
        if (tmr_cnt_q == cmp1_sh) begin
          tmr_cnt_d    = '0;
          period_end_d = 1'b1;
          sh_d         = sh_load;
        end else begin
          tmr_cnt_d = tmr_cnt_q + TMR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sh_q         <= '0;
      tmr_cnt_q    <= '0;
      tmr_value_q  <= '0;
      pwm_out_q    <= IDLE_LEVEL;
      period_end_q <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      tmr_cnt_q    <= tmr_cnt_d;
      tmr_value_q  <= tmr_cnt_d;
      pwm_out_q    <= pwm_out_d;
      period_end_q <= period_end_d;
    end
  end

  assign pwm_out    = pwm_out_q;
  assign period_end = period_end_q;
  assign tmr_value  = tmr_value_q;

endmodule
